// File: rtl/maindec.sv
// Multicycle main-control FSM: sequences fetch, decode and per-opcode execution
// and decodes datapath controls from the registered state (plus memready).
module maindec (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       memready,
    output logic       memwrite,
    output logic       lord,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic       branch,
    output logic       pcwrite,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic [3:0] state
);

    localparam int unsigned OP_W = 6;

    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    state_t     r_state;
    state_t     w_next;

    logic       w_memwrite;
    logic       w_lord;
    logic       w_irwrite;
    logic       w_regdst;
    logic       w_memtoreg;
    logic       w_regwrite;
    logic       w_alusrca;
    logic       w_branch;
    logic       w_pcwrite;
    logic [1:0] w_alusrcb;
    logic [1:0] w_pcsrc;
    logic [1:0] w_aluop;

    // State register; reset drops straight back to FETCH, aborting any instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and control decode; anything not driven in a state stays 0.
    always_comb begin
        w_next     = S_FETCH;
        w_memwrite = 1'b0;
        w_lord     = 1'b0;
        w_irwrite  = 1'b0;
        w_regdst   = 1'b0;
        w_memtoreg = 1'b0;
        w_regwrite = 1'b0;
        w_alusrca  = 1'b0;
        w_branch   = 1'b0;
        w_pcwrite  = 1'b0;
        w_alusrcb  = 2'b00;
        w_pcsrc    = 2'b00;
        w_aluop    = 2'b00;

        case (r_state)
            S_FETCH: begin
                w_alusrcb = 2'b01;
                w_irwrite = memready;
                w_pcwrite = memready;
                w_next    = memready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                w_alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXECUTE;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JUMP;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                case (op)
                    OP_LW:   w_next = S_MEMRD;
                    OP_SW:   w_next = S_MEMWR;
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEMRD: begin
                w_lord = 1'b1;
                w_next = memready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                w_memtoreg = 1'b1;
                w_regwrite = 1'b1;
            end
            S_MEMWR: begin
                // Write strobe held for the whole wait so memory sees a stable request.
                w_lord     = 1'b1;
                w_memwrite = 1'b1;
                w_next     = memready ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                w_alusrca = 1'b1;
                w_aluop   = 2'b10;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                w_regdst   = 1'b1;
                w_regwrite = 1'b1;
            end
            S_BRANCH: begin
                w_alusrca = 1'b1;
                w_aluop   = 2'b01;
                w_pcsrc   = 2'b01;
                w_branch  = 1'b1;
            end
            S_ADDIEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                w_next    = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_regwrite = 1'b1;
            end
            S_JUMP: begin
                w_pcsrc   = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Enables are qualified by reset so nothing writes while reset is held.
    assign memwrite = w_memwrite & reset;
    assign irwrite  = w_irwrite  & reset;
    assign regwrite = w_regwrite & reset;
    assign pcwrite  = w_pcwrite  & reset;
    assign branch   = w_branch   & reset;

    assign lord     = w_lord;
    assign regdst   = w_regdst;
    assign memtoreg = w_memtoreg;
    assign alusrca  = w_alusrca;
    assign alusrcb  = w_alusrcb;
    assign pcsrc    = w_pcsrc;
    assign aluop    = w_aluop;
    assign state    = r_state;

endmodule
